// File: rtl/stage3_mem_req.sv
// EX-stage data SRAM request issue with flush draining of orphaned requests and discard of stale data_ok.
// Optional address-wait performance counter enabled by MEM_REQ_PERF_CNT_EN.
module stage3_mem_req #(
  parameter int unsigned CNT_W = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        es_valid,
  input  logic        es_mem_req,
  input  logic        es_mem_we,
  input  logic [1:0]  es_mem_size,
  input  logic [31:0] es_mem_addr,
  input  logic [3:0]  es_mem_wstrb,
  input  logic [31:0] es_mem_wdata,
  input  logic        ms_ex,
  input  logic        flush,
  input  logic        ms_allow_in,
  output logic        es_mem_ready_go,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  output logic        ms_data_ok,
  output logic [31:0] req_stall_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ADDR = 2'd1,
    ACCEPTED  = 2'd2,
    DRAIN     = 2'd3
  } state_e;

  state_e state, state_nxt;
  logic   start;
  logic   hs;

  logic        cp_wr;
  logic [1:0]  cp_size;
  logic [31:0] cp_addr;
  logic [3:0]  cp_wstrb;
  logic [31:0] cp_wdata;

  logic [CNT_W-1:0] out_cnt, out_nxt;
  logic [CNT_W-1:0] disc_cnt, disc_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state, request strobe, handshake and EX hand-off
  always_comb begin
    state_nxt       = state;
    start           = 1'b0;
    data_sram_req   = 1'b0;
    hs              = 1'b0;
    es_mem_ready_go = 1'b0;

    start         = es_valid & es_mem_req & ~ms_ex & ~flush & (state == IDLE);
    data_sram_req = start | (state == WAIT_ADDR) | (state == DRAIN);
    hs            = data_sram_req & data_sram_addr_ok;

    case (state)
      IDLE: begin
        if (start & ~hs)              state_nxt = WAIT_ADDR;
        else if (hs & ~ms_allow_in)   state_nxt = ACCEPTED;
      end
      WAIT_ADDR: begin
        if (flush & ~hs)              state_nxt = DRAIN;
        else if (flush & hs)          state_nxt = IDLE;
        else if (hs)                  state_nxt = ms_allow_in ? IDLE : ACCEPTED;
      end
      ACCEPTED: begin
        if (flush | ms_allow_in)      state_nxt = IDLE;
      end
      DRAIN: begin
        if (hs)                       state_nxt = IDLE;
      end
      default:                        state_nxt = IDLE;
    endcase

    es_mem_ready_go = (state != DRAIN) &
                      (~es_mem_req |
                       (ms_ex & (state == IDLE)) |
                       (hs & ((state == IDLE) | (state == WAIT_ADDR))) |
                       (state == ACCEPTED));
  end

  // An orphaned request keeps presenting the fields it had when EX was flushed
  always_comb begin
    data_sram_wr    = es_mem_we;
    data_sram_size  = es_mem_size;
    data_sram_addr  = es_mem_addr;
    data_sram_wstrb = es_mem_wstrb;
    data_sram_wdata = es_mem_wdata;
    if (state == DRAIN) begin
      data_sram_wr    = cp_wr;
      data_sram_size  = cp_size;
      data_sram_addr  = cp_addr;
      data_sram_wstrb = cp_wstrb;
      data_sram_wdata = cp_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cp_wr    <= 1'b0;
      cp_size  <= 2'd0;
      cp_addr  <= 32'd0;
      cp_wstrb <= 4'd0;
      cp_wdata <= 32'd0;
    end else if (data_sram_req) begin
      cp_wr    <= data_sram_wr;
      cp_size  <= data_sram_size;
      cp_addr  <= data_sram_addr;
      cp_wstrb <= data_sram_wstrb;
      cp_wdata <= data_sram_wdata;
    end
  end

  // Outstanding and discard counters, both saturating
  always_comb begin
    out_nxt  = out_cnt;
    disc_nxt = disc_cnt;

    if (hs & ~data_sram_data_ok & (out_cnt != '1))
      out_nxt = out_cnt + CNT_W'(1);
    else if (data_sram_data_ok & ~hs & (out_cnt != '0))
      out_nxt = out_cnt - CNT_W'(1);

    if (flush) begin
      disc_nxt = out_nxt;
    end else begin
      if ((state == DRAIN) & hs & ~(data_sram_data_ok & (disc_cnt != '0)) & (disc_cnt != '1))
        disc_nxt = disc_cnt + CNT_W'(1);
      else if (data_sram_data_ok & (disc_cnt != '0) & ~((state == DRAIN) & hs))
        disc_nxt = disc_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_cnt  <= '0;
      disc_cnt <= '0;
    end else begin
      out_cnt  <= out_nxt;
      disc_cnt <= disc_nxt;
    end
  end

  assign ms_data_ok = data_sram_data_ok & (disc_cnt == '0);

`ifdef MEM_REQ_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                     stall_q <= 32'd0;
    else if ((state == WAIT_ADDR) | (state == DRAIN)) stall_q <= stall_q + 32'd1;
  end

  assign req_stall_cnt = stall_q;
`else
  assign req_stall_cnt = 32'd0;
`endif

endmodule
